// File: rtl/apu_spdif_pkg.sv
// Shared constants for the S/PDIF (IEC 60958 consumer) transmitter: preambles,
// channel-status block, slot positions and the encoder state type.
package apu_spdif_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } spdif_state_e;

  // Preambles as 8 half-cell levels, MSB first, for a preceding line level of 0.
  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  localparam int FRAMES_PER_BLOCK = 192;

  localparam logic [4:0] SLOT_AUDIO_LSB = 5'd4;
  localparam logic [4:0] SLOT_V         = 5'd28;
  localparam logic [4:0] SLOT_U         = 5'd29;
  localparam logic [4:0] SLOT_C         = 5'd30;
  localparam logic [4:0] SLOT_P         = 5'd31;

  // Bit n is channel-status bit n: copy permitted, 48 kHz, 24-bit words.
  localparam logic [191:0] CS_BITS = 192'hB_0200_0004;

  function automatic logic [7:0] preamble_for(input logic right, input logic block_start);
    if (right)            return PRE_W;
    else if (block_start) return PRE_B;
    else                  return PRE_M;
  endfunction

endpackage

// File: rtl/spdif_bmc_serializer.sv
// Biphase-mark line driver: turns one requested half-cell (preamble level or
// data bit) into the registered line level, tracking the previous level.
module spdif_bmc_serializer
  import apu_spdif_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_step,
  input  logic i_first,
  input  logic i_is_pre,
  input  logic i_pre_bit,
  input  logic i_half,
  input  logic i_data,
  output logic o_line
);

  logic r_line;
  logic r_inv;
  logic w_inv;
  logic w_next;

  // The preamble polarity is fixed by the line level just before half-cell 0.
  always_comb begin
    w_inv  = i_first ? r_line : r_inv;
    w_next = r_line;
    if (i_is_pre) begin
      w_next = i_pre_bit ^ w_inv;
    end else if (!i_half) begin
      w_next = ~r_line;
    end else if (i_data) begin
      w_next = ~r_line;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_line <= 1'b0;
      r_inv  <= 1'b0;
    end else if (i_step) begin
      r_line <= w_next;
      if (i_first) begin
        r_inv <= r_line;
      end
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/apu_spdif_encoder.sv
// S/PDIF transmitter top: sample holding register, frame/subframe/half-cell
// counters, slot multiplexer with parity, and the IDLE/RUN control.
module apu_spdif_encoder
  import apu_spdif_pkg::*;
#(
  parameter int CLKS_PER_HALFCELL       = 2,
  parameter bit CS_VALIDITY_ON_UNDERRUN = 1'b1
) (
  input  logic        MCLK_i,
  input  logic        RST_i,
  input  logic        EN_i,
  input  logic [23:0] PDATA_LEFT_i,
  input  logic [23:0] PDATA_RIGHT_i,
  input  logic        PDATA_VALID_i,
  output logic        SPDIF_o,
  output logic        FRAME_START_o,
  output logic        UNDERRUN_o
);

  localparam int DIV_W = (CLKS_PER_HALFCELL > 1) ? $clog2(CLKS_PER_HALFCELL) : 1;

  spdif_state_e     r_state;
  spdif_state_e     w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_hc;
  logic             r_ch;
  logic [7:0]       r_frame;
  logic [23:0]      r_hold_l;
  logic [23:0]      r_hold_r;
  logic [23:0]      r_shift_l;
  logic [23:0]      r_shift_r;
  logic             r_fresh;
  logic             r_vbit;
  logic             r_frame_start;
  logic             r_underrun;

  logic             w_active;
  logic             w_div_last;
  logic             w_step;
  logic             w_load;
  logic [4:0]       w_slot;
  logic [4:0]       w_audio_idx;
  logic [23:0]      w_sample;
  logic             w_cbit;
  logic             w_parity;
  logic             w_slot_bit;
  logic             w_is_pre;
  logic [7:0]       w_pre_pat;
  logic             w_pre_bit;
  logic             w_line;

  always_ff @(posedge MCLK_i) begin
    if (RST_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (EN_i)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!EN_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Dropping EN_i aborts the frame in the same cycle it is seen.
  assign w_active   = (r_state == ST_RUN) && EN_i;
  assign w_div_last = (r_div == DIV_W'(CLKS_PER_HALFCELL - 1));
  assign w_step     = w_active && (r_div == '0);
  assign w_load     = w_step && (r_hc == 6'd0) && !r_ch;

  always_ff @(posedge MCLK_i) begin
    if (RST_i || !w_active) begin
      r_div   <= '0;
      r_hc    <= 6'd0;
      r_ch    <= 1'b0;
      r_frame <= 8'd0;
    end else if (w_div_last) begin
      r_div <= '0;
      r_hc  <= r_hc + 6'd1;
      if (r_hc == 6'd63) begin
        r_ch <= ~r_ch;
        if (r_ch) begin
          r_frame <= (r_frame == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : r_frame + 8'd1;
        end
      end
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // A strobe in the load cycle still sets fresh, so that pair waits a frame.
  always_ff @(posedge MCLK_i) begin
    if (RST_i) begin
      r_hold_l  <= 24'd0;
      r_hold_r  <= 24'd0;
      r_fresh   <= 1'b0;
      r_shift_l <= 24'd0;
      r_shift_r <= 24'd0;
      r_vbit    <= 1'b0;
    end else begin
      if (w_load) begin
        r_shift_l <= r_hold_l;
        r_shift_r <= r_hold_r;
        r_vbit    <= CS_VALIDITY_ON_UNDERRUN & ~r_fresh;
      end
      if (PDATA_VALID_i) begin
        r_hold_l <= PDATA_LEFT_i;
        r_hold_r <= PDATA_RIGHT_i;
        r_fresh  <= 1'b1;
      end else if (w_load) begin
        r_fresh <= 1'b0;
      end
    end
  end

  assign w_slot      = r_hc[5:1];
  assign w_audio_idx = w_slot - SLOT_AUDIO_LSB;
  assign w_sample    = r_ch ? r_shift_r : r_shift_l;
  assign w_cbit      = CS_BITS[r_frame];
  assign w_parity    = ^{w_sample, r_vbit, 1'b0, w_cbit};
  assign w_is_pre    = (r_hc[5:3] == 3'd0);
  assign w_pre_pat   = preamble_for(r_ch, r_frame == 8'd0);
  assign w_pre_bit   = w_pre_pat[3'd7 - r_hc[2:0]];

  always_comb begin
    w_slot_bit = 1'b0;
    case (w_slot)
      SLOT_V:  w_slot_bit = r_vbit;
      SLOT_U:  w_slot_bit = 1'b0;
      SLOT_C:  w_slot_bit = w_cbit;
      SLOT_P:  w_slot_bit = w_parity;
      default: w_slot_bit = w_sample[w_audio_idx];
    endcase
  end

  spdif_bmc_serializer u_bmc (
    .i_clk    (MCLK_i),
    .i_rst    (RST_i),
    .i_clear  (!w_active),
    .i_step   (w_step),
    .i_first  (r_hc == 6'd0),
    .i_is_pre (w_is_pre),
    .i_pre_bit(w_pre_bit),
    .i_half   (r_hc[0]),
    .i_data   (w_slot_bit),
    .o_line   (w_line)
  );

  always_ff @(posedge MCLK_i) begin
    if (RST_i) begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_fresh;
    end
  end

  assign SPDIF_o       = w_line;
  assign FRAME_START_o = r_frame_start;
  assign UNDERRUN_o    = r_underrun;

endmodule

// File: tb/tb_apu_spdif_encoder.sv
// Bench for apu_spdif_encoder: frame-level line model checked every cycle,
// plus a BMC decoder feeding hand-computed expectations.
module tb_apu_spdif_encoder;

  localparam int CPH       = 2;
  localparam int FRAME_CYC = 128 * CPH;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid;
  logic [23:0] pl;
  logic [23:0] pr;
  logic        spdif;
  logic        fs;
  logic        ur;

  int checks   = 0;
  int failures = 0;
  int ur_cnt   = 0;

  always #5 clk = ~clk;

  apu_spdif_encoder #(
    .CLKS_PER_HALFCELL      (CPH),
    .CS_VALIDITY_ON_UNDERRUN(1'b1)
  ) dut (
    .MCLK_i       (clk),
    .RST_i        (rst),
    .EN_i         (en),
    .PDATA_LEFT_i (pl),
    .PDATA_RIGHT_i(pr),
    .PDATA_VALID_i(valid),
    .SPDIF_o      (spdif),
    .FRAME_START_o(fs),
    .UNDERRUN_o   (ur)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cs_bit(input int n);
    return (n == 2) || (n == 25) || (n == 32) || (n == 33) || (n == 35);
  endfunction

  function automatic logic [23:0] pat_l(input int k);
    return 24'(k * 32'h0001_0203 + 32'h00A5_0F01);
  endfunction

  function automatic logic [23:0] pat_r(input int k);
    return 24'((k * 32'h0013_5791) ^ 32'h005A_5A5A);
  endfunction

  // ---------------- frame-level model ----------------
  logic        m_valid = 1'b0;
  logic        m_run, m_fresh, m_line, m_fs, m_ur;
  logic [23:0] m_hl, m_hr;
  int          m_t, m_fn;
  logic        m_lv[128];

  task automatic build_frame(input logic [23:0] l, input logic [23:0] r, input logic v, input int fn);
    logic        lvl;
    logic        inv;
    logic [31:0] bits;
    logic [7:0]  pat;
    logic [23:0] s;
    int          ones;
    lvl = m_line;
    for (int sub = 0; sub < 2; sub++) begin
      s    = (sub == 1) ? r : l;
      pat  = (sub == 1) ? 8'hE4 : ((fn == 0) ? 8'hE8 : 8'hE2);
      bits = '0;
      for (int k = 0; k < 24; k++) bits[4+k] = s[k];
      bits[28] = v;
      bits[29] = 1'b0;
      bits[30] = cs_bit(fn);
      ones = 0;
      for (int k = 4; k < 31; k++) ones += int'(bits[k]);
      bits[31] = (ones % 2) == 1;
      inv = lvl;
      for (int i = 0; i < 8; i++) m_lv[sub*64+i] = pat[7-i] ^ inv;
      lvl = m_lv[sub*64+7];
      for (int j = 4; j < 32; j++) begin
        lvl = ~lvl;
        m_lv[sub*64+2*j] = lvl;
        if (bits[j]) lvl = ~lvl;
        m_lv[sub*64+2*j+1] = lvl;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    m_fs = 1'b0;
    m_ur = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_run   = 1'b0;
      m_fresh = 1'b0;
      m_hl    = 24'd0;
      m_hr    = 24'd0;
      m_line  = 1'b0;
    end else begin
      if (!m_run) begin
        m_line = 1'b0;
        if (en) begin
          m_run = 1'b1;
          m_t   = 0;
          m_fn  = 0;
        end
      end else if (!en) begin
        m_run  = 1'b0;
        m_line = 1'b0;
      end else begin
        if (m_t % FRAME_CYC == 0) begin
          build_frame(m_hl, m_hr, !m_fresh, m_fn);
          m_fs    = 1'b1;
          m_ur    = !m_fresh;
          m_fresh = 1'b0;
          m_fn    = (m_fn + 1) % 192;
        end
        m_line = m_lv[(m_t % FRAME_CYC) / CPH];
        m_t++;
      end
      if (valid) begin
        m_hl    = pl;
        m_hr    = pr;
        m_fresh = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("line", 32'(spdif), 32'(m_line));
      check("frame_start", 32'(fs), 32'(m_fs));
      check("underrun", 32'(ur), 32'(m_ur));
    end
    if (ur === 1'b1) ur_cnt++;
  end

  // ---------------- line decoder ----------------
  logic        a_hc[128];
  logic        cap = 1'b0;
  logic        fprev = 1'b0;
  logic        prev_line = 1'b0;
  int          cyc = 0;
  logic [23:0] d_l[$];
  logic [23:0] d_r[$];
  logic        d_vl[$];
  logic        d_vr[$];
  logic        d_c[$];
  logic        d_pl[$];
  logic        d_pr[$];
  logic [7:0]  d_pre_l[$];

  task automatic decode_frame();
    logic        p;
    logic [7:0]  pre[2];
    logic [31:0] bits[2];
    for (int sub = 0; sub < 2; sub++) begin
      p = (sub == 1) ? a_hc[63] : fprev;
      pre[sub]  = '0;
      bits[sub] = '0;
      for (int i = 0; i < 8; i++) pre[sub][7-i] = a_hc[sub*64+i] ^ p;
      for (int j = 4; j < 32; j++) bits[sub][j] = a_hc[sub*64+2*j] ^ a_hc[sub*64+2*j+1];
      check((sub == 1) ? "parity_r" : "parity_l", 32'(^bits[sub][31:4]), 32'd0);
    end
    check("pre_w", 32'(pre[1]), 32'hE4);
    check("c_lr", 32'(bits[0][30]), 32'(bits[1][30]));
    d_l.push_back(bits[0][27:4]);
    d_r.push_back(bits[1][27:4]);
    d_vl.push_back(bits[0][28]);
    d_vr.push_back(bits[1][28]);
    d_c.push_back(bits[0][30]);
    d_pl.push_back(bits[0][31]);
    d_pr.push_back(bits[1][31]);
    d_pre_l.push_back(pre[0]);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst !== 1'b0 || !en) begin
      cap = 1'b0;
    end else begin
      if (fs) begin
        cap   = 1'b1;
        cyc   = 0;
        fprev = prev_line;
      end
      if (cap) begin
        if (cyc % CPH == 0) a_hc[cyc/CPH] = spdif;
        if (cyc == FRAME_CYC - CPH) begin
          decode_frame();
          cap = 1'b0;
        end
        cyc++;
      end
    end
    prev_line = spdif;
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic [23:0] l, input logic [23:0] r);
    @(posedge clk);
    #1;
    valid = 1'b1;
    pl    = l;
    pr    = r;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    @(negedge clk);
    while (!fs && n < FRAME_CYC + 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fs !== 1'b1) begin
      failures++;
      $display("FAIL wait_fs timeout actual=%0d cycles required=<=%0d", n, FRAME_CYC);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [191:0] cs_exp;
    logic [191:0] cvec;
    int           ur0;
    rst   = 1'b1;
    en    = 1'b1;
    valid = 1'b0;
    pl    = 24'd0;
    pr    = 24'd0;
    cs_exp = 192'hB_0200_0004;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_line", 32'(spdif), 32'd0);
      check("rst_fs", 32'(fs), 32'd0);
      check("rst_ur", 32'(ur), 32'd0);
    end
    rst   = 1'b0;
    valid = 1'b1;
    pl    = 24'h000001;
    pr    = 24'h800000;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    check("start_idle_fs", 32'(fs), 32'd0);
    check("start_idle_line", 32'(spdif), 32'd0);
    @(negedge clk);
    check("start_b_fs", 32'(fs), 32'd1);
    check("start_b_line", 32'(spdif), 32'd1);

    // single pair in frame 0
    strobe(pat_l(1), pat_r(1));
    wait_fs();
    check("f0_left", 32'(d_l[0]), 32'h000001);
    check("f0_right", 32'(d_r[0]), 32'h800000);
    check("f0_pl", 32'(d_pl[0]), 32'd1);
    check("f0_pr", 32'(d_pr[0]), 32'd1);
    check("f0_vl", 32'(d_vl[0]), 32'd0);
    check("f0_vr", 32'(d_vr[0]), 32'd0);
    check("f0_pre_b", 32'(d_pre_l[0]), 32'hE8);

    // continuous feed across a block wrap
    for (int k = 2; k < 196; k++) begin
      strobe(pat_l(k), pat_r(k));
      wait_fs();
    end
    for (int i = 1; i < 195; i++) begin
      check("feed_left", 32'(d_l[i]), 32'(pat_l(i)));
      check("feed_right", 32'(d_r[i]), 32'(pat_r(i)));
    end
    for (int i = 0; i < 195; i++) begin
      check("pre_left", 32'(d_pre_l[i]), (i % 192 == 0) ? 32'hE8 : 32'hE2);
    end
    cvec = '0;
    for (int i = 0; i < 192; i++) cvec[i] = d_c[i];
    for (int w = 0; w < 6; w++) check("cs_block", cvec[32*w +: 32], cs_exp[32*w +: 32]);

    // underrun: frames 196 and 197 get no new pair
    ur0 = ur_cnt;
    wait_fs();
    wait_fs();
    strobe(pat_l(198), pat_r(198));
    wait_fs();
    check("ur_pulses", 32'(ur_cnt - ur0), 32'd2);
    check("ur_frames", 32'(d_l.size()), 32'd198);
    for (int i = 196; i < 198; i++) begin
      check("ur_left", 32'(d_l[i]), 32'(pat_l(195)));
      check("ur_right", 32'(d_r[i]), 32'(pat_r(195)));
      check("ur_vl", 32'(d_vl[i]), 32'd1);
      check("ur_vr", 32'(d_vr[i]), 32'd1);
    end

    // overrun: latest pair wins
    strobe(24'h111111, 24'h111111);
    repeat (20) @(posedge clk);
    strobe(24'h222222, 24'h222222);
    wait_fs();
    wait_fs();
    check("ovr_left", 32'(d_l[199]), 32'h222222);
    check("ovr_right", 32'(d_r[199]), 32'h222222);

    // strobe in the frame-load cycle waits one frame
    repeat (FRAME_CYC - 1) @(posedge clk);
    #1;
    valid = 1'b1;
    pl    = 24'h333333;
    pr    = 24'h333333;
    @(posedge clk);
    #1;
    valid = 1'b0;
    wait_fs();
    wait_fs();
    wait_fs();
    check("load_held_left", 32'(d_l[201]), 32'h222222);
    check("load_held_v", 32'(d_vl[201]), 32'd1);
    check("load_next_left", 32'(d_l[202]), 32'h333333);
    check("load_next_v", 32'(d_vl[202]), 32'd0);

    // enable drop mid-subframe, then re-enable
    repeat (40) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop_line", 32'(spdif), 32'd0);
    check("drop_fs", 32'(fs), 32'd0);
    repeat (1000) @(posedge clk);
    #1;
    en    = 1'b1;
    valid = 1'b1;
    pl    = 24'h444444;
    pr    = 24'h0F0F0F;
    @(posedge clk);
    #1;
    valid = 1'b0;
    wait_fs();
    wait_fs();
    wait_fs();
    check("reen_frames", 32'(d_l.size()), 32'd205);
    check("reen_pre_b", 32'(d_pre_l[203]), 32'hE8);
    check("reen_left", 32'(d_l[203]), 32'h444444);
    check("reen_right", 32'(d_r[203]), 32'h0F0F0F);
    check("reen_v", 32'(d_vl[203]), 32'd0);
    check("reen_pre_m", 32'(d_pre_l[204]), 32'hE2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
